// File: rtl/mux_nto1_buf.sv
// N-way result-select mux with fixed or round-robin channel choice,
// feeding a 2-entry {data,src} output buffer with valid/ready handshaking.
module mux_nto1_buf #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clkpos,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    rr_en,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [1:0]       count;
  logic [SEL_W-1:0] rr_ptr;
  logic [WIDTH-1:0] tail_data;
  logic [SEL_W-1:0] tail_src;

  logic             space;
  logic             sel_bad;
  logic             grant_found;
  logic             push;
  logic             pop;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] next_ptr;
  logic [WIDTH-1:0] grant_data;
  logic [SEL_W-1:0] grant_hi;
  logic [SEL_W-1:0] grant_lo;
  logic             found_hi;
  logic             found_lo;

  // Room is judged from the registered count only, so ready never depends on out_ready.
  assign space     = (count != 2'd2);
  assign sel_bad   = (int'(sel) >= NUM_IN);
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = |(in_ready & in_valid);
  assign next_ptr  = (int'(grant) == NUM_IN - 1) ? '0 : grant + SEL_W'(1);

  // Round-robin: lowest valid channel at or above rr_ptr wins, else lowest below it.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        if (i >= int'(rr_ptr)) begin
          grant_hi = SEL_W'(i);
          found_hi = 1'b1;
        end else begin
          grant_lo = SEL_W'(i);
          found_lo = 1'b1;
        end
      end
    end
    if (rr_en) begin
      grant       = found_hi ? grant_hi : grant_lo;
      grant_found = found_hi | found_lo;
    end else begin
      grant       = sel;
      grant_found = !sel_bad;
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == grant) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = grant_found & space;
      end
    end
  end

  // The head entry lives directly in out_data/out_src so it holds its value once popped.
  always_ff @(posedge clkpos or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      rr_ptr    <= '0;
      out_data  <= '0;
      out_src   <= '0;
      tail_data <= '0;
      tail_src  <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= !rr_en && sel_bad;
      if (push && rr_en) begin
        rr_ptr <= next_ptr;
      end
      case ({push, pop})
        2'b10: begin
          count <= count + 2'd1;
          if (count == 2'd0) begin
            out_data <= grant_data;
            out_src  <= grant;
          end else begin
            tail_data <= grant_data;
            tail_src  <= grant;
          end
        end
        2'b01: begin
          count <= count - 2'd1;
          if (count == 2'd2) begin
            out_data <= tail_data;
            out_src  <= tail_src;
          end
        end
        2'b11: begin
          out_data <= grant_data;
          out_src  <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule
